f2h_axi_burst_writer: RTL and testbench

- Parametrised AXI3 write master that drives the HPS FPGA-to-HPS (f2h) slave port.
- Packs an ADC sample stream into DATA_W-bit beats and buffers them in an on-chip FIFO.
- Issues fixed-length INCR bursts into a circular buffer in HPS SDRAM.
- Next generation of the single-beat f2h path: adds width, burst-length, FIFO-depth and wrap-around generality, plus status reporting for the HPS software.

---
 rtl/f2h_axi_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/f2h_axi_burst_writer.sv | 254 +++++++++++++++++++++++++
 tb/tb_f2h_axi_burst_writer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f2h_axi_pkg.sv
// Shared AXI3 constants, FSM state type and sizing helper for the f2h burst writer.
package f2h_axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } state_t;

    // AXI awsize encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] calc_awsize(input int data_w);
        logic [2:0] size;
        size = 3'd0;
        for (int s = 0; s < 8; s++) begin
            if ((1 << s) == (data_w / 8)) begin
                size = 3'(s);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read: dout always shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    // Storage array write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/f2h_axi_burst_writer.sv
// AXI3 burst write master for the HPS f2h port: packs samples into beats, buffers them
// and writes fixed-length INCR bursts into a circular SDRAM buffer.
// Optional build macro F2H_WRITER_FLUSH_EN adds a flush input that drains a partial burst.
module f2h_axi_burst_writer
    import f2h_axi_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SAMPLE_W   = 16,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int ID_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
`ifdef F2H_WRITER_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [31:0]           buf_base,
    input  logic [31:0]           buf_bytes,
    input  logic [SAMPLE_W-1:0]   s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ID_W-1:0]       awid,
    output logic [31:0]           awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic [4:0]            awuser,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_W-1:0]       wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [31:0]           wr_offset,
    output logic [15:0]           wrap_cnt,
    output logic                  err,
    output logic                  busy
);

    localparam int SPB        = DATA_W / SAMPLE_W;
    localparam int IDX_W      = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_BYTES = DATA_W / 8;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   pack_reg, pack_next, push_data_reg, fifo_dout;
    logic [IDX_W-1:0]    pack_idx_reg;
    logic                push_reg;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full, fifo_empty, fifo_pop;
    logic [4:0]          beat_cnt_reg, burst_beats_reg, start_beats;
    logic [31:0]         wr_offset_reg, offset_adv;
    logic [15:0]         wrap_cnt_reg;
    logic                err_reg;
    logic                sample_fire, pack_last, room_ok, start_full, start_burst;
    logic                flush_pad, w_last;

    // A pending packer push counts against free space so a one-sample-per-beat
    // configuration cannot overrun the FIFO.
    assign room_ok     = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, push_reg}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign start_full  = enable && (fifo_count >= CNT_W'(BURST_LEN));
    assign sample_fire = s_valid && s_ready;
    assign pack_last   = (pack_idx_reg == IDX_W'(SPB - 1));
    assign fifo_pop    = (state_reg == W) && wready && !fifo_empty;
    assign w_last      = (beat_cnt_reg == burst_beats_reg - 5'd1);
    assign offset_adv  = wr_offset_reg + 32'(burst_beats_reg) * 32'(BEAT_BYTES);

`ifdef F2H_WRITER_FLUSH_EN
    logic flush_req_reg;
    logic flush_go;

    assign flush_pad   = flush_req_reg && !push_reg && (pack_idx_reg != '0);
    assign flush_go    = flush_req_reg && !push_reg && (pack_idx_reg == '0) &&
                         (fifo_count != '0) && (fifo_count < CNT_W'(BURST_LEN));
    assign s_ready     = enable && !reset && !fifo_full && room_ok && !flush_req_reg;
    assign start_burst = start_full || flush_go;
    assign start_beats = start_full ? 5'(BURST_LEN) : 5'(fifo_count);

    // Flush request: latched in IDLE, held while the partial beat is padded, dropped once a burst starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_req_reg <= 1'b0;
        end else if (state_reg == IDLE && start_burst) begin
            flush_req_reg <= 1'b0;
        end else if (flush && state_reg == IDLE) begin
            flush_req_reg <= 1'b1;
        end else if (flush_req_reg && !push_reg && pack_idx_reg == '0 && fifo_count == '0) begin
            flush_req_reg <= 1'b0;
        end
    end
`else
    assign flush_pad   = 1'b0;
    assign s_ready     = enable && !reset && !fifo_full && room_ok;
    assign start_burst = start_full;
    assign start_beats = 5'(BURST_LEN);
`endif

    // Each lane takes the incoming sample when the packer index points at it; lane 0 is the first sample.
    genvar gi;
    generate
        for (gi = 0; gi < SPB; gi++) begin : g_lane
            assign pack_next[gi*SAMPLE_W +: SAMPLE_W] =
                (pack_idx_reg == IDX_W'(gi)) ? s_data : pack_reg[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    // Packer: collect samples and hand a complete (or zero-padded) beat to the FIFO one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            pack_reg      <= '0;
            pack_idx_reg  <= '0;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
        end else begin
            push_reg <= 1'b0;
            if (sample_fire) begin
                if (pack_last) begin
                    push_data_reg <= pack_next;
                    pack_reg      <= '0;
                    pack_idx_reg  <= '0;
                    push_reg      <= 1'b1;
                end else begin
                    pack_reg     <= pack_next;
                    pack_idx_reg <= pack_idx_reg + IDX_W'(1);
                end
            end else if (flush_pad) begin
                push_data_reg <= pack_reg;
                pack_reg      <= '0;
                pack_idx_reg  <= '0;
                push_reg      <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_reg),
        .din   (push_data_reg),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: one burst at a time, AW then W beats then the B response.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_burst)         state_next = AW;
            AW:      if (awready)             state_next = W;
            W:       if (fifo_pop && w_last)  state_next = B;
            B:       if (bvalid)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // FSM outputs: channel payloads are driven only while their valid is up, zero otherwise.
    always_comb begin
        awvalid = 1'b0;
        awaddr  = '0;
        awlen   = '0;
        awsize  = '0;
        awburst = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        bready  = 1'b0;
        case (state_reg)
            AW: begin
                awvalid = 1'b1;
                awaddr  = buf_base + wr_offset_reg;
                awlen   = 4'(burst_beats_reg - 5'd1);
                awsize  = calc_awsize(DATA_W);
                awburst = BURST_INCR;
            end
            W: begin
                wvalid = 1'b1;
                wdata  = fifo_dout;
                wstrb  = '1;
                wlast  = w_last;
            end
            B:       bready = 1'b1;
            default: ;
        endcase
    end

    // Burst bookkeeping: beat counter, ring pointer, wrap counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_reg    <= '0;
            burst_beats_reg <= '0;
            wr_offset_reg   <= '0;
            wrap_cnt_reg    <= '0;
            err_reg         <= 1'b0;
        end else begin
            if (state_reg == IDLE && start_burst) begin
                burst_beats_reg <= start_beats;
            end
            if (state_reg == AW) begin
                beat_cnt_reg <= '0;
            end else if (fifo_pop) begin
                beat_cnt_reg <= beat_cnt_reg + 5'd1;
            end
            if (state_reg == B && bvalid) begin
                // A response carrying a foreign ID is treated like an error response.
                err_reg <= err_reg | (bresp != RESP_OKAY) | (bid != '0);
                if (offset_adv >= buf_bytes) begin
                    wr_offset_reg <= '0;
                    wrap_cnt_reg  <= wrap_cnt_reg + 16'd1;
                end else begin
                    wr_offset_reg <= offset_adv;
                end
            end
        end
    end

    assign awid      = '0;
    assign wid       = '0;
    assign awlock    = 2'b00;
    assign awcache   = 4'b0000;
    assign awprot    = 3'b000;
    assign awuser    = 5'b00000;
    assign wr_offset = wr_offset_reg;
    assign wrap_cnt  = wrap_cnt_reg;
    assign err       = err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_f2h_axi_burst_writer.sv
// Self-checking bench for f2h_axi_burst_writer: scoreboard of packed beats, ring-pointer model.
module tb_f2h_axi_burst_writer;

    localparam int DATA_W     = 32;
    localparam int SAMPLE_W   = 16;
    localparam int BURST_LEN  = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int ID_W       = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] RING = 32'd64;

    logic                clk;
    logic                reset;
    logic                enable;
`ifdef F2H_WRITER_FLUSH_EN
    logic                flush;
`endif
    logic [31:0]         buf_base, buf_bytes;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid, s_ready;
    logic [ID_W-1:0]     awid, wid, bid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize, awprot;
    logic [1:0]          awburst, awlock, bresp;
    logic [3:0]          awcache;
    logic [4:0]          awuser;
    logic                awvalid, awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast, wvalid, wready;
    logic                bvalid, bready;
    logic [31:0]         wr_offset;
    logic [15:0]         wrap_cnt;
    logic                err, busy;

    f2h_axi_burst_writer #(
        .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .BURST_LEN(BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
`ifdef F2H_WRITER_FLUSH_EN
        .flush(flush),
`endif
        .buf_base(buf_base), .buf_bytes(buf_bytes),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awuser(awuser),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .wr_offset(wr_offset), .wrap_cnt(wrap_cnt), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard and reference model state.
    logic [31:0] exp_q[$];
    logic [31:0] pack_model = '0;
    int          pack_k = 0;
    logic [31:0] model_off = '0;
    logic [15:0] wrap_model = '0;
    logic        err_model = 1'b0;
    bit          b_pend = 0;
    int          beat_idx = 0;
    int          aw_total = 0, beat_total = 0, b_total = 0;
    logic [31:0] last_awaddr = '0;
    bit          aw_stall_prev = 0, w_stall_prev = 0;
    logic [31:0] aw_prev_addr = '0, w_prev_data = '0;
    int          seq = 1;
    int          got;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, sampled mid-cycle: inputs change only just after the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pack_model    = '0;
            pack_k        = 0;
            model_off     = '0;
            wrap_model    = '0;
            err_model     = 1'b0;
            b_pend        = 0;
            aw_stall_prev = 0;
            w_stall_prev  = 0;
        end else begin
            if (b_pend) begin
                chk("wr_offset", wr_offset, model_off);
                chk("wrap_cnt", wrap_cnt, wrap_model);
                chk("err", err, err_model);
                b_pend = 0;
            end
            if (aw_stall_prev) chk("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev_addr});
            aw_stall_prev = awvalid && !awready;
            aw_prev_addr  = awaddr;
            if (w_stall_prev) chk("w_hold", {wvalid, wdata}, {1'b1, w_prev_data});
            w_stall_prev = wvalid && !wready;
            w_prev_data  = wdata;

            if (s_valid && s_ready) begin
                pack_model = pack_model | (32'(s_data) << (SAMPLE_W * pack_k));
                pack_k++;
                if (pack_k == DATA_W / SAMPLE_W) begin
                    exp_q.push_back(pack_model);
                    pack_model = '0;
                    pack_k = 0;
                end
            end
            if (awvalid && awready) begin
                $display("AW  addr=0x%08h len=%0d", awaddr, awlen);
                chk("awaddr", awaddr, BASE + model_off);
                chk("awlen", awlen, BURST_LEN - 1);
                chk("awsize", awsize, 3'd2);
                chk("awburst", awburst, 2'b01);
                last_awaddr = awaddr;
                beat_idx = 0;
                aw_total++;
            end
            if (wvalid && wready) begin
                $display("W   beat=%0d data=0x%08h last=%0b", beat_idx, wdata, wlast);
                if (exp_q.size() == 0) begin
                    chk("w_unexpected_beat", exp_q.size(), 1);
                end else begin
                    chk("wdata", wdata, exp_q.pop_front());
                end
                chk("wlast", wlast, beat_idx == BURST_LEN - 1);
                chk("wstrb", wstrb, 4'hF);
                beat_idx++;
                beat_total++;
            end
            if (bvalid && bready) begin
                $display("B   resp=%0d", bresp);
                err_model = err_model | (bresp != 2'b00);
                model_off = model_off + 32'(BURST_LEN * DATA_W / 8);
                if (model_off == RING) begin
                    model_off = '0;
                    wrap_model++;
                end
                b_pend = 1;
                b_total++;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    // Drive n samples, waiting at most max_wait cycles for each acceptance.
    task automatic stream(input int n, input int max_wait, output int accepted);
        bit ok;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = seq[15:0];
            ok = 0;
            for (int w = 0; w < max_wait && !ok; w++) begin
                @(negedge clk);
                ok = s_ready;
                if (!ok) begin
                    @(posedge clk); #1;
                end
            end
            if (!ok) begin
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            accepted++;
            seq++;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && (pack_k == 0);
        end
        chk(tag, done, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_wvalid(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wvalid) break;
        end
        chk(tag, wvalid, 1'b1);
    endtask

    task automatic wait_b(input int target);
        for (int i = 0; i < 500 && b_total < target; i++) @(negedge clk);
        chk("b_wait", b_total >= target, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_aw"}, {awvalid, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awuser}, 64'd0);
        chk({tag, "_w"}, {wvalid, wlast, wstrb, wdata, wid}, 64'd0);
        chk({tag, "_stat"}, {wr_offset, wrap_cnt, err, busy, bready, s_ready}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int aw0, b0, bt0;
        reset = 1'b1; enable = 1'b0;
`ifdef F2H_WRITER_FLUSH_EN
        flush = 1'b0;
`endif
        buf_base = BASE; buf_bytes = RING;
        s_valid = 1'b0; s_data = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; bid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        // 1: one burst of four beats.
        apply_reset();
        aw0 = aw_total;
        stream(8, 20, got);
        chk("t1_accepted", got, 8);
        drain("t1_drain");
        chk("t1_offset", wr_offset, 32'd16);
        chk("t1_bursts", aw_total - aw0, 1);

        // 2: four bursts wrap the ring once.
        apply_reset();
        aw0 = aw_total;
        stream(32, 20, got);
        chk("t2_accepted", got, 32);
        drain("t2_drain");
        chk("t2_offset", wr_offset, 32'd0);
        chk("t2_wrap", wrap_cnt, 16'd1);
        chk("t2_bursts", aw_total - aw0, 4);

        // 3: wready stall for five cycles after two beats.
        bt0 = beat_total;
        wready = 1'b0;
        stream(8, 20, got);
        wait_wvalid("t3_wvalid");
        @(posedge clk); #1; wready = 1'b1;
        repeat (2) @(posedge clk);
        #1; wready = 1'b0;
        repeat (5) @(posedge clk);
        #1; wready = 1'b1;
        drain("t3_drain");
        chk("t3_beats", beat_total - bt0, 4);
        chk("t3_offset", wr_offset, 32'd16);

        // 4: SLVERR on the second burst of three.
        b0 = b_total;
        aw0 = aw_total;
        fork
            stream(24, 20, got);
            begin
                wait_b(b0 + 1);
                @(posedge clk); #1; bresp = 2'b10;
                wait_b(b0 + 2);
                @(posedge clk); #1; bresp = 2'b00;
            end
        join
        drain("t4_drain");
        chk("t4_err", err, 1'b1);
        chk("t4_offset", wr_offset, 32'd0);
        chk("t4_wrap", wrap_cnt, 16'd2);
        chk("t4_bursts", aw_total - aw0, 3);

        // 5: address channel blocked until the FIFO fills.
        awready = 1'b0;
        aw0 = aw_total;
        stream(40, 30, got);
        chk("t5_accepted", got, FIFO_DEPTH * DATA_W / SAMPLE_W);
        @(negedge clk);
        chk("t5_s_ready", s_ready, 1'b0);
        @(posedge clk); #1; awready = 1'b1;
        drain("t5_drain");
        chk("t5_bursts", aw_total - aw0, FIFO_DEPTH / BURST_LEN);
        chk("t5_wrap", wrap_cnt, 16'd3);

        // 6: reset in the W state after two beats.
        wready = 1'b0;
        stream(8, 20, got);
        wait_wvalid("t6_wvalid");
        @(posedge clk); #1; wready = 1'b1;
        repeat (2) @(posedge clk);
        #1; wready = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("t6_reset");
        @(posedge clk); #1;
        reset = 1'b0; wready = 1'b1;
        stream(8, 20, got);
        drain("t6_drain");
        chk("t6_addr", last_awaddr, BASE);
        chk("t6_offset", wr_offset, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
